// File: rtl/mem_pkg.sv
// Shared definitions for the memory read path: access-size codes, beat
// decoding and the burst reader FSM state encoding.
package mem_pkg;

   localparam logic [1:0] ACC_1W  = 2'b00;
   localparam logic [1:0] ACC_4W  = 2'b01;
   localparam logic [1:0] ACC_8W  = 2'b10;
   localparam logic [1:0] ACC_16W = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   function automatic logic [4:0] acc_beats(input logic [1:0] size);
      logic [4:0] beats;
      case (size)
         ACC_1W:  beats = 5'd1;
         ACC_4W:  beats = 5'd4;
         ACC_8W:  beats = 5'd8;
         default: beats = 5'd16;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/burst_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned burst words.
// Head output reads as zero while empty.
module burst_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       head_valid,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             pop_ok;

   // A pop while empty is ignored; a push is never refused because the
   // producer only starts a burst when enough entries are free.
   assign pop_ok     = pop && (count_q != '0);
   assign head_valid = (count_q != '0);
   assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
   assign count      = count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator: issues 1/4/8/16-word reads and streams the returned
// words out through a FIFO. MEM_BURST_READER_ALIGN_CHECK_EN rejects misaligned starts.
module mem_burst_reader
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [1:0]            mem_access_size,
   output logic                  mem_rw,
   output logic                  mem_enable,
   input  logic                  mem_busy,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  err
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   rd_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [1:0]            size_q;
   logic [4:0]            beats_q;
   logic [4:0]            issued_q;
   logic [4:0]            ret_cnt_q;
   logic                  issue_vld_p1;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W-1:0]      free_cnt;
   logic                  accept;
   logic                  misaligned;
   logic                  beat_fire;
   logic                  last_issue;
   logic                  push_last;
   logic [DATA_WIDTH:0]   head_word;

   assign beats_q    = acc_beats(size_q);
   assign free_cnt   = CNT_W'(FIFO_DEPTH) - fifo_count;
   assign accept     = req_valid && req_ready;
   assign beat_fire  = (state_q == ISSUE) && !mem_busy;
   assign last_issue = (issued_q == beats_q - 5'd1);
   assign push_last  = (ret_cnt_q == beats_q - 5'd1);
   assign mem_rw     = 1'b0;

`ifdef MEM_BURST_READER_ALIGN_CHECK_EN
   logic err_q;
   assign misaligned = |req_addr[1:0];
   assign err        = err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         err_q <= 1'b0;
      else
         err_q <= accept && misaligned;
   end
`else
   assign misaligned = 1'b0;
   assign err        = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && !misaligned) state_d = ISSUE;
         ISSUE:   if (beat_fire && last_issue) state_d = DRAIN;
         DRAIN:   if (issue_vld_p1 && push_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address and size are only driven while a burst is being issued.
   always_comb begin
      req_ready       = 1'b0;
      mem_enable      = 1'b0;
      mem_address     = '0;
      mem_access_size = 2'b00;
      case (state_q)
         IDLE: req_ready = reset_n && (free_cnt >= CNT_W'(acc_beats(req_size)));
         ISSUE: begin
            mem_enable      = 1'b1;
            mem_address     = base_q + ADDR_WIDTH'({issued_q, 2'b00});
            mem_access_size = size_q;
         end
         default: ;
      endcase
   end

   // Stage p0: beat issue; stage p1: memory returns the word for capture.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         issued_q     <= '0;
         ret_cnt_q    <= '0;
         issue_vld_p1 <= 1'b0;
      end else begin
         issue_vld_p1 <= beat_fire;
         if (accept)
            issued_q <= '0;
         else if (beat_fire)
            issued_q <= issued_q + 5'd1;
         if (accept)
            ret_cnt_q <= '0;
         else if (issue_vld_p1)
            ret_cnt_q <= ret_cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         base_q <= req_addr;
         size_q <= req_size;
      end
   end

   burst_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (issue_vld_p1),
      .push_data  ({push_last, mem_data}),
      .pop        (out_ready),
      .head_valid (out_valid),
      .head_data  (head_word),
      .count      (fifo_count)
   );

   assign out_data = head_word[DATA_WIDTH-1:0];
   assign out_last = head_word[DATA_WIDTH];

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Read initiator for the byte-addressable instruction/data memory. Accepts a single read request (start address plus access size) from a consumer, drives the memory's address/access_size/rw/enable port to issue a 1/4/8/16-word burst, and captures the returned words into an internal FIFO. The consumer receives the words over a valid/ready stream, with the last word of each burst tagged. It sits between the fetch/load logic and `memory`.

## Interface
- `DATA_WIDTH`, 32, memory data width in bits.
- `ADDR_WIDTH`, 32, memory address width in bits.
- `FIFO_DEPTH`, 16, return-word buffer depth in entries; must be a power of two and at least 16.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  consumer request present.
- `req_ready`  out  1  request accepted on the cycle where `req_valid && req_ready`.
- `req_addr`  in  ADDR_WIDTH  burst start byte address.
- `req_size`  in  2  burst size code: 00 = 1 word, 01 = 4 words, 10 = 8 words, 11 = 16 words.
- `mem_address`  out  ADDR_WIDTH  to `memory.address`.
- `mem_access_size`  out  2  to `memory.access_size`.
- `mem_rw`  out  1  to `memory.rw`; held at 0 (read only).
- `mem_enable`  out  1  to `memory.enable`.
- `mem_busy`  in  1  from `memory.busy`; a high value stalls beat issue.
- `mem_data`  in  DATA_WIDTH  from `memory.data_out`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer pops the head on `out_valid && out_ready`.
- `out_data`  out  DATA_WIDTH  FIFO head word.
- `out_last`  out  1  head word is the final word of its burst.
- `err`  out  1  one-cycle pulse on a rejected request (see Configuration).

## Operation
- FSM states:
  - IDLE: `req_ready` = (free FIFO entries ≥ beats(`req_size`)). On accept, latch the address and size, clear the issue counter, and go to ISSUE.
  - ISSUE: `mem_enable` = 1. `mem_address` = latched start address + 4·issued. `mem_access_size` = latched size.
    - A beat is issued on each cycle where `!mem_busy`; the issue counter increments on that cycle.
    - After the final beat is issued, go to DRAIN.
  - DRAIN: `mem_enable` = 0. Wait for the final returned word to be written, then go to IDLE.
- Return path: a 1-bit delay flag marks that the previous cycle issued a beat. While the flag is set, `mem_data` is pushed into the FIFO together with a last bit (the return counter equals beats−1).
- The memory cannot be back-pressured, so pushes never fail. This is guaranteed by the space check in IDLE.
- FIFO entries are {last, data}. Simultaneous push and pop are legal at any occupancy, including full and empty. Occupancy counter width is log2(FIFO_DEPTH)+1.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is allowed and not flagged.
- beats() is 1/4/8/16 and is held in a 5-bit counter.

## Timing
- Reset values: `req_ready` 0 while in reset, `mem_enable` 0, `mem_rw` 0, `mem_address` 0, `mem_access_size` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `err` 0. The FIFO is emptied and the FSM returns to IDLE.
- Reset asserted mid-burst aborts the burst. Words still in flight are discarded.
- Request accepted at edge T: the first beat is issued in cycle T+1 (if `mem_busy` is 0), the word is captured at the end of T+2, and `out_valid` rises in T+3.
- With no busy cycles, an N-word burst occupies N ISSUE cycles plus 1 DRAIN cycle. The next request can be accepted in the cycle after DRAIN.
- `out_valid` stays high until popped. `out_data`/`out_last` are stable while `out_valid && !out_ready`.

## Configuration
- `MEM_BURST_READER_ALIGN_CHECK_EN` defined: a request with `req_addr[1:0] != 0` is accepted but issues no memory access. `err` pulses for one cycle, the FSM stays in IDLE, and nothing is pushed.
- Macro undefined: `err` is tied to 0, the low address bits pass through unchanged, and every request is executed.

## Structure
- Shared package `mem_pkg`:
  - access-size codes `ACC_1W`, `ACC_4W`, `ACC_8W`, `ACC_16W`;
  - function `acc_beats(size)` returning 5 bits;
  - FSM state enum {IDLE, ISSUE, DRAIN}.
- One sub-module, `burst_fifo`: a synchronous FIFO with parameterised width and depth, asynchronous active-low reset, and first-word-fall-through output.

## Test plan
- Single word: `req_addr`=0x80020000, size 00, `mem_busy`=0. Expect exactly one enable cycle at 0x80020000, then `out_valid` at T+3 with `out_last`=1.
- 16-word burst from 0x80020040 with `out_ready`=1. Expect 16 consecutive enable cycles on addresses 0x80020040…0x8002007C, 16 words delivered in order, and `out_last` on word 16 only.
- `mem_busy` high for 3 cycles mid 8-word burst. Expect the address to hold during the stall, no duplicate or missing words, and 8 words total.
- `out_ready`=0 after a 16-word burst so the FIFO fills to 16. Expect `req_ready`=0 for any size until pops free at least beats(size) entries. Then pop and push on the same cycle at full occupancy, and expect no loss.
- `reset_n` pulsed low during beat 5 of a 16-word burst. Expect all outputs at reset values immediately, an empty FIFO, and a clean new 4-word burst afterwards.
- With `MEM_BURST_READER_ALIGN_CHECK_EN`: `req_addr`=0x80020002. Expect a one-cycle `err` pulse, no `mem_enable`, and no output.
